// File: rtl/mac_feeder.sv
// mac_feeder: drains operand FIFOs A and B in lockstep and hands paired operands to the MAC.
// Optional stall_cycles counter is built when MAC_FEEDER_STALL_CNT_EN is defined.
`timescale 1ns/1ps

module mac_feeder #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8,
    localparam int CW        = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  a_empty,
    input  logic                  b_empty,
    output logic                  a_rden,
    output logic                  b_rden,
    input  logic [DATA_WIDTH-1:0] a_rddata,
    input  logic [DATA_WIDTH-1:0] b_rddata,
    output logic                  op_valid,
    input  logic                  op_ready,
    output logic [DATA_WIDTH-1:0] op_a,
    output logic [DATA_WIDTH-1:0] op_b,
    output logic                  op_last,
    output logic [CW-1:0]         count,
    output logic [1:0]            state,
    output logic                  done
`ifdef MAC_FEEDER_STALL_CNT_EN
    ,
    output logic [15:0]           stall_cycles
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [CW-1:0] DEPTH_C    = CW'(DEPTH);
    localparam logic [CW-1:0] LAST_IDX_C = CW'(DEPTH - 1);

    function automatic logic [CW-1:0] sat_inc_cnt(input logic [CW-1:0] v);
        return (v == DEPTH_C) ? v : v + 1'b1;
    endfunction

    state_t                state_q;
    state_t                state_d;
    logic [CW-1:0]         issued_q;
    logic [CW-1:0]         count_q;
    logic                  start_go;
    logic                  rd_en;
    logic                  pop;
    logic [2:0]            occ_after;

    // Read stage: a pop issued in p0 returns data in p1
    logic                  rd_vld_p1;
    logic                  rd_last_p1;

    // Two-entry output buffer holding {a, b, last}
    logic [DATA_WIDTH-1:0] buf_a_q    [2];
    logic [DATA_WIDTH-1:0] buf_b_q    [2];
    logic                  buf_last_q [2];
    logic                  wr_ptr_q;
    logic                  rd_ptr_q;
    logic [1:0]            occ_q;

    assign op_valid = (occ_q != 2'd0);
    assign op_a     = buf_a_q[rd_ptr_q];
    assign op_b     = buf_b_q[rd_ptr_q];
    assign op_last  = op_valid && buf_last_q[rd_ptr_q];
    assign a_rden   = rd_en;
    assign b_rden   = rd_en;
    assign count    = count_q;
    assign state    = state_q;
    assign done     = (state_q == ST_DONE);

    always_comb begin
        state_d   = state_q;
        start_go  = 1'b0;
        rd_en     = 1'b0;
        pop       = op_valid && op_ready;
        // Slots committed after this cycle: buffered + landing read - leaving pair
        occ_after = {1'b0, occ_q} + {2'b00, rd_vld_p1} - {2'b00, pop};
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    start_go = 1'b1;
                    state_d  = ST_RUN;
                end
            end
            ST_RUN: begin
                rd_en = !a_empty && !b_empty && (issued_q < DEPTH_C) &&
                        (occ_after < 3'd2);
                if (pop && op_last) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (start) begin
                    start_go = 1'b1;
                    state_d  = ST_RUN;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issued_q <= '0;
            count_q  <= '0;
        end else if (start_go) begin
            issued_q <= '0;
            count_q  <= '0;
        end else begin
            if (rd_en) begin
                issued_q <= sat_inc_cnt(issued_q);
            end
            if (pop) begin
                count_q <= sat_inc_cnt(count_q);
            end
        end
    end

    // ---- p0 -> p1: FIFO read latency ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_vld_p1  <= 1'b0;
            rd_last_p1 <= 1'b0;
        end else begin
            rd_vld_p1  <= rd_en;
            rd_last_p1 <= rd_en && (issued_q == LAST_IDX_C);
        end
    end

    // ---- p1 -> buffer: capture returning data the cycle it is valid ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            occ_q    <= 2'd0;
        end else if (start_go) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            occ_q    <= 2'd0;
        end else begin
            if (rd_vld_p1) begin
                wr_ptr_q <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            case ({rd_vld_p1, pop})
                2'b10:   occ_q <= occ_q + 2'd1;
                2'b01:   occ_q <= occ_q - 2'd1;
                default: occ_q <= occ_q;
            endcase
        end
    end

    // Storage is cleared on reset so the operand outputs read zero out of reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                buf_a_q[i]    <= '0;
                buf_b_q[i]    <= '0;
                buf_last_q[i] <= 1'b0;
            end
        end else if (rd_vld_p1) begin
            buf_a_q[wr_ptr_q]    <= a_rddata;
            buf_b_q[wr_ptr_q]    <= b_rddata;
            buf_last_q[wr_ptr_q] <= rd_last_p1;
        end
    end

`ifdef MAC_FEEDER_STALL_CNT_EN
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles <= 16'd0;
        end else if (start_go) begin
            stall_cycles <= 16'd0;
        end else if ((state_q == ST_RUN) && !pop) begin
            stall_cycles <= sat_inc16(stall_cycles);
        end
    end
`endif

endmodule

// File: doc/mac_feeder.md
# mac_feeder

Read-side sequencer that drains the two operand FIFOs (A and B) in lockstep and presents paired operands to the MAC over a valid/ready handshake. It counts exactly DEPTH pairs per run, flags the final pair, and then parks in DONE. Its state code drives LEDR[1:0] (IDLE=0, RUN=1, DONE=2). It is the consumer counterpart of the FIFO fill logic in the Minilab0 datapath.

## Interface
- DATA_WIDTH, 8: width of each FIFO entry and operand.
- DEPTH, 8: operand pairs consumed per run; legal range 1..255.
- CW, $clog2(DEPTH+1): count width (derived, not overridden).

- clk  in  1  single clock; all logic is on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  begins a run; sampled only in IDLE or DONE.
- a_empty, b_empty  in  1 each  FIFO empty flags.
- a_rden, b_rden  out  1 each  pop strobes; always equal.
- a_rddata, b_rddata  in  DATA_WIDTH each  FIFO read data; valid the cycle after rden.
- op_valid  out  1  operand pair valid.
- op_ready  in  1  MAC accepts the pair.
- op_a, op_b  out  DATA_WIDTH each  operand pair.
- op_last  out  1  high with the DEPTH-th pair.
- count  out  CW  pairs accepted by the MAC this run.
- state  out  2  0=IDLE, 1=RUN, 2=DONE (3 is unused).
- done  out  1  high while state==DONE.
- stall_cycles  out  16  present only with MAC_FEEDER_STALL_CNT_EN.

## Operation
- IDLE: start=1 moves the block to RUN and clears the issued and accepted counters.
- RUN: a_rden=b_rden=1 only when all of the following hold:
  - !a_empty && !b_empty;
  - issued < DEPTH;
  - (buffer occupancy + reads in flight − pop this cycle) < 2.
- Output buffer:
  - Two-entry FIFO of {a,b,last}; the head drives op_a/op_b/op_last.
  - Returning read data is written into the buffer on the cycle it is valid.
- Pop: occurs when op_valid && op_ready; count increments on each pop.
- RUN→DONE: on the pop of the pair with op_last=1.
- DONE: done=1 and state is held. start=1 returns to RUN, clears the counters and drops done the next cycle.
- start while in RUN is ignored.
- While op_valid && !op_ready, op_a/op_b/op_last hold stable.
- An empty FIFO stalls issue only. Buffered pairs continue to drain.
- Arithmetic: counters use CW bits with no wrap; issued saturates at DEPTH.
- Data passes through unmodified; there is no sign or width conversion.

## Timing
- Reset values: all outputs 0. This includes a_rden, b_rden, op_valid, op_a, op_b, op_last, count, state (IDLE), done and stall_cycles.
- Reset mid-run takes effect immediately and asynchronously. In-flight reads are discarded; the FIFOs are not rewound.
- With start sampled in cycle 0, both FIFOs non-empty and op_ready held high:
  - state=1 and the first rden occur in cycle 1;
  - first op_valid in cycle 3;
  - one pair per cycle through cycle DEPTH+2;
  - state=2 and done=1 in cycle DEPTH+3.
- Latency from rden to op_valid is 2 cycles: one cycle of FIFO read latency plus one buffer write.
- A pop and a returning read in the same cycle are both honoured, so occupancy is unchanged.

## Configuration
- MAC_FEEDER_STALL_CNT_EN
  - Defined: the stall_cycles port exists. It counts RUN cycles where op_valid=0 or op_ready=0, saturates at 16'hFFFF, and clears on start.
  - Undefined: the port and counter are absent. All other behaviour is identical.

## Test plan
- Full-rate run:
  - Stimulus: A preloaded with 0,5,…,35 and B with 0,10,…,70; op_ready=1; start pulsed in cycle 0.
  - Response: pairs (0,0)…(35,70) in cycles 3–10, op_last in cycle 10, state=2 and done=1 in cycle 11, count=8. The scoreboard dot product is 7000 (0x1B58).
- Backpressure:
  - Stimulus: op_ready toggles 1,0,1,0….
  - Response: 8 pairs in order with none lost or duplicated; operands stable while stalled; at most 2 buffered-plus-in-flight reads at any time.
- Empty stall:
  - Stimulus: b_empty held high in cycles 4–7.
  - Response: rden low in those cycles; the remaining pairs follow in order; with STALL_CNT_EN, stall_cycles ≥ 4.
- Reset mid-run:
  - Stimulus: rst_n low after 3 accepted pairs.
  - Response: all outputs 0 in the same cycle with state=0. After release, a fresh start yields 8 new pairs.
- Restart:
  - Stimulus: start pulsed in DONE; start also pulsed mid-RUN.
  - Response: the DONE start gives done=0 and state=1 the next cycle. The mid-RUN start has no effect, and count still ends at 8.
- DEPTH=1 build:
  - Stimulus: one pair in each FIFO.
  - Response: a single beat with op_last=1 in cycle 3; DONE in cycle 4.
